// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore data-memory access stage.
// Holds the opcode and funct3 encodings, the access-size codes, the
// access FSM state type and a small alignment helper.
package fewcore_pkg;

  // Major opcodes (operation[6:0])
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3 encodings (operation[9:7])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size codes (funct3[1:0])
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  // True when an access of the given size cannot be served at byte offset k.
  // Size code 11 has no RV32I meaning and is reported as misaligned so it
  // never reaches memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] k);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = k[0];
      SZ_WORD: mis = (k != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for the memory access stage.
// Ports:
//   size          access size code (byte/half/word)
//   k             byte offset within the word (addr[1:0])
//   store_data    rs2 value to be written
//   rdata         little-endian word read from memory
//   wstrb         byte enables, bit n = byte at offset n
//   wdata         store data replicated across all lanes
//   rdata_aligned read data shifted so the addressed item sits in the MSBs
//   misaligned    access cannot be served at this offset
module mem_align
  import fewcore_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  k,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata_aligned,
  output logic        misaligned
);

  // Lane selection and read alignment by access size
  always_comb begin
    wstrb         = 4'b0000;
    wdata         = 32'h0000_0000;
    rdata_aligned = rdata;
    misaligned    = is_misaligned(size, k);
    case (size)
      SZ_BYTE: begin
        wstrb         = 4'b0001 << k;
        wdata         = {4{store_data[7:0]}};
        // shift by 8*(3-k); 3-k is the bitwise inverse of k
        rdata_aligned = rdata << {~k, 3'b000};
      end
      SZ_HALF: begin
        wstrb         = 4'b0011 << k;
        wdata         = {2{store_data[15:0]}};
        // only k = 0 or 2 are legal: shift 16 for k=0, 0 for k=2
        rdata_aligned = rdata << {~k[1], 4'b0000};
      end
      SZ_WORD: begin
        wstrb         = 4'b1111;
        wdata         = store_data;
        rdata_aligned = rdata;
      end
      default: begin
        wstrb         = 4'b0000;
        wdata         = 32'h0000_0000;
        rdata_aligned = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage of the fewcore RV32I pipeline.
// Accepts a load/store from execute, runs one req/ack transaction with data
// memory and returns load data with the addressed byte/half in the MSBs.
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   valid, operation,    candidate op from execute ({.., funct3, opcode}),
//   addr, storeData,     effective address, store data, store flag
//   isStore
//   mem_req/we/addr/     memory request, word address, lane-replicated data
//   wdata/wstrb          and byte enables (held stable while requesting)
//   mem_rdata, mem_ack   memory read word and completion strobe
//   memData              aligned load data (updated on load completion only)
//   stall                freeze upstream while an op is accepted or in flight
//   done, misaligned,    one-cycle completion / alignment-exception /
//   fault                timeout pulses
module mem_access
  import fewcore_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  input  logic            isStore,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ack,
  output logic [31:0]     memData,
  output logic            stall,
  output logic            done,
  output logic            misaligned,
  output logic            fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              done_q, done_d;
  logic              misaligned_q, misaligned_d;
  logic              fault_q, fault_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        k_q, k_d;
  logic              load_q, load_d;

  logic [6:0]  opcode_s;
  logic [1:0]  size_s;
  logic [1:0]  k_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        mem_op_s;
  logic [1:0]  al_size_s;
  logic [1:0]  al_k_s;
  logic [3:0]  al_wstrb_s;
  logic [31:0] al_wdata_s;
  logic [31:0] al_rdata_s;
  logic        al_misaligned_s;
  logic        unused_s;

  assign opcode_s   = operation[6:0];
  assign size_s     = operation[8:7];
  assign k_s        = addr[1:0];
  assign is_load_s  = (opcode_s == OP_LOAD);
  assign is_store_s = (opcode_s == OP_STORE) && isStore;
  assign mem_op_s   = is_load_s || is_store_s;

  // Upper funct bits and the unsigned-load bit are consumed by execute.
  assign unused_s = &{1'b0, operation[11:9]};

  // In IDLE the aligner looks at the incoming op; afterwards at the latched op
  // so the read word is aligned with the size/offset of the accepted access.
  assign al_size_s = (state_q == IDLE) ? size_s : size_q;
  assign al_k_s    = (state_q == IDLE) ? k_s : k_q;

  mem_align u_align (
    .size          (al_size_s),
    .k             (al_k_s),
    .store_data    (storeData[31:0]),
    .rdata         (mem_rdata),
    .wstrb         (al_wstrb_s),
    .wdata         (al_wdata_s),
    .rdata_aligned (al_rdata_s),
    .misaligned    (al_misaligned_s)
  );

  // Next-state and registered-output computation for the access FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_data_d   = mem_data_q;
    size_d       = size_q;
    k_d          = k_q;
    load_d       = load_q;
    done_d       = 1'b0;
    misaligned_d = 1'b0;
    fault_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid && mem_op_s) begin
          if (al_misaligned_s) begin
            // exception is reported without touching memory; stay in IDLE
            misaligned_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            state_d     = BUSY;
            cnt_d       = CNT_ZERO;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_s;
            mem_addr_d  = {addr[XLEN-1:2], 2'b00};
            mem_wdata_d = is_store_s ? al_wdata_s : 32'h0000_0000;
            mem_wstrb_d = is_store_s ? al_wstrb_s : 4'b0000;
            size_d      = size_s;
            k_d         = k_s;
            load_d      = is_load_s;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        // an ack in the final allowed cycle completes normally, not as a fault
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          done_d     = 1'b1;
          mem_data_d = load_q ? al_rdata_s : mem_data_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          fault_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {XLEN{1'b0}};
      mem_wdata_q  <= 32'h0000_0000;
      mem_wstrb_q  <= 4'b0000;
      mem_data_q   <= 32'h0000_0000;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      size_q       <= 2'b00;
      k_q          <= 2'b00;
      load_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_data_q   <= mem_data_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
      size_q       <= size_d;
      k_q          <= k_d;
      load_q       <= load_d;
    end
  end

  assign stall      = ((state_q == IDLE) && valid && mem_op_s && !al_misaligned_s)
                      || (state_q == BUSY);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign memData    = mem_data_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import fewcore_pkg::*;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [11:0] operation;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        isStore;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] memData;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        mis;
    logic        flt;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_access #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid(valid), .operation(operation),
    .addr(addr), .storeData(storeData), .isStore(isStore),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .memData(memData), .stall(stall), .done(done),
    .misaligned(misaligned), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [6:0] opc,
                          input logic [31:0] a, input logic [31:0] sd, input logic st);
    valid     = 1'b1;
    operation = {2'b00, f3, opc};
    addr      = a;
    storeData = sd;
    isStore   = st;
  endtask

  task automatic push(input logic mis, input logic flt, input logic [31:0] data);
    exp_t e;
    e.mis  = mis;
    e.flt  = flt;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every done pulse retires the oldest expected completion
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_unexpected_done: observed done=1 expected no pending op");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          chk("sb_fault", {31'd0, fault}, {31'd0, e.flt});
          chk("sb_memData", memData, e.data);
        end
      end else if (misaligned || fault) begin
        chk("pulse_without_done", {30'd0, misaligned, fault}, 32'd0);
      end
    end
  end

  initial begin
    int req_cycles;
    reset = 1'b1; valid = 1'b0; operation = 12'h000; addr = 32'h0;
    storeData = 32'h0; isStore = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_memData", memData, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    cyc();
    reset = 1'b0;

    // LB at 0x101, ack on first BUSY cycle
    cyc();
    drive_op(F3_LB, OP_LOAD, 32'h0000_0101, 32'h0, 1'b0);
    mem_rdata = 32'hAABB_CCDD;
    push(1'b0, 1'b0, 32'hCCDD_0000);
    @(negedge clk);
    chk("lb_stall_n", {31'd0, stall}, 32'd1);
    chk("lb_req_n", {31'd0, mem_req}, 32'd0);
    cyc();
    valid = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("lb_req", {31'd0, mem_req}, 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    chk("lb_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("lb_stall_n1", {31'd0, stall}, 32'd1);
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lb_done", {31'd0, done}, 32'd1);
    chk("lb_stall_done", {31'd0, stall}, 32'd0);

    // SH at 0x202, ack on third BUSY cycle; inputs disturbed while busy
    cyc();
    drive_op(F3_SH, OP_STORE, 32'h0000_0202, 32'h1234_BEEF, 1'b1);
    push(1'b0, 1'b0, 32'hCCDD_0000);
    @(negedge clk);
    chk("sh_stall_n", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      valid = 1'b1; addr = 32'h0000_0555; storeData = 32'h5555_5555;
      mem_ack = (i == 2);
      @(negedge clk);
      chk("sh_req", {31'd0, mem_req}, 32'd1);
      chk("sh_we", {31'd0, mem_we}, 32'd1);
      chk("sh_addr", mem_addr, 32'h0000_0200);
      chk("sh_wstrb", {28'd0, mem_wstrb}, 32'h0000_000C);
      chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    end
    cyc();
    valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("sh_done", {31'd0, done}, 32'd1);
    chk("sh_req_drop", {31'd0, mem_req}, 32'd0);
    cyc();
    @(negedge clk);
    chk("sh_done_1cyc", {31'd0, done}, 32'd0);

    // LW at 0x102: misaligned, no request
    cyc();
    drive_op(F3_LW, OP_LOAD, 32'h0000_0102, 32'h0, 1'b0);
    push(1'b1, 1'b0, 32'hCCDD_0000);
    @(negedge clk);
    chk("lwm_stall", {31'd0, stall}, 32'd0);
    cyc();
    valid = 1'b0;
    @(negedge clk);
    chk("lwm_mis", {31'd0, misaligned}, 32'd1);
    chk("lwm_req", {31'd0, mem_req}, 32'd0);
    cyc();
    @(negedge clk);
    chk("lwm_mis_1cyc", {31'd0, misaligned}, 32'd0);
    chk("lwm_req2", {31'd0, mem_req}, 32'd0);

    // LW at 0x100, zero-wait memory
    cyc();
    drive_op(F3_LW, OP_LOAD, 32'h0000_0100, 32'h0, 1'b0);
    mem_rdata = 32'h1122_3344;
    push(1'b0, 1'b0, 32'h1122_3344);
    cyc();
    valid = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lw_done", {31'd0, done}, 32'd1);

    // SW at 0x10 with no ack: timeout after exactly 4 request cycles
    cyc();
    drive_op(F3_SW, OP_STORE, 32'h0000_0010, 32'hCAFE_F00D, 1'b1);
    push(1'b0, 1'b1, 32'h1122_3344);
    req_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      valid = 1'b0;
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (done) break;
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd4);
    chk("to_done", {31'd0, done}, 32'd1);

    // LBU at 0x3 right after the fault
    cyc();
    drive_op(F3_LBU, OP_LOAD, 32'h0000_0003, 32'h0, 1'b0);
    mem_rdata = 32'h5566_7788;
    push(1'b0, 1'b0, 32'h5566_7788);
    cyc();
    valid = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lbu_done", {31'd0, done}, 32'd1);

    // LHU at 0x6, reset in the second BUSY cycle, late ack ignored
    cyc();
    drive_op(F3_LHU, OP_LOAD, 32'h0000_0006, 32'h0, 1'b0);
    cyc();
    valid = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("lhu_req_busy2", {31'd0, mem_req}, 32'd1);
    cyc();
    reset = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("rst2_req", {31'd0, mem_req}, 32'd0);
    chk("rst2_addr", mem_addr, 32'd0);
    chk("rst2_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk("rst2_wdata", mem_wdata, 32'd0);
    chk("rst2_memData", memData, 32'd0);
    chk("rst2_pulses", {29'd0, done, misaligned, fault}, 32'd0);
    chk("rst2_stall", {31'd0, stall}, 32'd0);
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_done", {31'd0, done}, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);

    // SB at 0x13: top lane
    cyc();
    drive_op(F3_SB, OP_STORE, 32'h0000_0013, 32'h0000_00A5, 1'b1);
    push(1'b0, 1'b0, 32'h0000_0000);
    cyc();
    valid = 1'b0;
    @(negedge clk);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h0000_0008);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr, 32'h0000_0010);
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;

    // LH at 0x0: ack arrives in the same cycle the timeout is reached
    cyc();
    drive_op(F3_LH, OP_LOAD, 32'h0000_0000, 32'h0, 1'b0);
    mem_rdata = 32'h0000_ABCD;
    push(1'b0, 1'b0, 32'hABCD_0000);
    for (int i = 0; i < 4; i++) begin
      cyc();
      valid = 1'b0;
      mem_ack = (i == 3);
    end
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lh_race_done", {31'd0, done}, 32'd1);
    chk("lh_race_fault", {31'd0, fault}, 32'd0);

    // ADD with valid, plus a stray ack in IDLE: nothing happens
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive_op(3'b000, OP_ADD, 32'h0000_0100, 32'h0, 1'b0);
      mem_ack = 1'b1;
      @(negedge clk);
      chk("add_stall", {31'd0, stall}, 32'd0);
      chk("add_req", {31'd0, mem_req}, 32'd0);
      chk("add_done", {31'd0, done}, 32'd0);
    end
    cyc();
    valid = 1'b0; mem_ack = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("add_memData", memData, 32'hABCD_0000);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
